// File: rtl/mem_responder.sv
// Memory-side responder: captures instruction-read, data-read and data-write requests
// in one batch, serialises them onto a single req/ack backing bus, and returns tagged read results.
module mem_responder #(
    parameter int unsigned TIMEOUT  = 256,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INST_RDEN,
    input  logic [31:0] INST_RIADDR,
    output logic [31:0] INST_ROADDR,
    output logic        INST_RVALID,
    output logic [31:0] INST_RDATA,
    input  logic        DATA_RDEN,
    input  logic [31:0] DATA_RIADDR,
    output logic [31:0] DATA_ROADDR,
    output logic        DATA_RVALID,
    output logic [31:0] DATA_RDATA,
    input  logic        DATA_WREN,
    input  logic [31:0] DATA_WADDR,
    input  logic [31:0] DATA_WDATA,
    output logic        MEM_WAIT,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic        BUS_ERR
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t      state_q, state_d;
    logic        w_vld_q, w_vld_d, dr_vld_q, dr_vld_d, ir_vld_q, ir_vld_d;
    logic [31:0] w_addr_q, w_addr_d, w_data_q, w_data_d;
    logic [31:0] dr_addr_q, dr_addr_d, ir_addr_q, ir_addr_d;
    logic        dr_rd_q, dr_rd_d, ir_rd_q, ir_rd_d;
    logic        err_q, err_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] dr_res_q, dr_res_d, ir_res_q, ir_res_d;
    logic [31:0] data_rdata_q, data_rdata_d, data_roaddr_q, data_roaddr_d;
    logic [31:0] inst_rdata_q, inst_rdata_d, inst_roaddr_q, inst_roaddr_d;
    logic        tmo_hit, slot_done;
    logic [31:0] rd_word;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            w_vld_q       <= 1'b0;
            dr_vld_q      <= 1'b0;
            ir_vld_q      <= 1'b0;
            w_addr_q      <= '0;
            w_data_q      <= '0;
            dr_addr_q     <= '0;
            ir_addr_q     <= '0;
            dr_rd_q       <= 1'b0;
            ir_rd_q       <= 1'b0;
            err_q         <= 1'b0;
            timer_q       <= '0;
            dr_res_q      <= '0;
            ir_res_q      <= '0;
            data_rdata_q  <= '0;
            data_roaddr_q <= '0;
            inst_rdata_q  <= '0;
            inst_roaddr_q <= '0;
        end else begin
            state_q       <= state_d;
            w_vld_q       <= w_vld_d;
            dr_vld_q      <= dr_vld_d;
            ir_vld_q      <= ir_vld_d;
            w_addr_q      <= w_addr_d;
            w_data_q      <= w_data_d;
            dr_addr_q     <= dr_addr_d;
            ir_addr_q     <= ir_addr_d;
            dr_rd_q       <= dr_rd_d;
            ir_rd_q       <= ir_rd_d;
            err_q         <= err_d;
            timer_q       <= timer_d;
            dr_res_q      <= dr_res_d;
            ir_res_q      <= ir_res_d;
            data_rdata_q  <= data_rdata_d;
            data_roaddr_q <= data_roaddr_d;
            inst_rdata_q  <= inst_rdata_d;
            inst_roaddr_q <= inst_roaddr_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        w_vld_d       = w_vld_q;
        dr_vld_d      = dr_vld_q;
        ir_vld_d      = ir_vld_q;
        w_addr_d      = w_addr_q;
        w_data_d      = w_data_q;
        dr_addr_d     = dr_addr_q;
        ir_addr_d     = ir_addr_q;
        dr_rd_d       = dr_rd_q;
        ir_rd_d       = ir_rd_q;
        err_d         = err_q;
        timer_d       = timer_q;
        dr_res_d      = dr_res_q;
        ir_res_d      = ir_res_q;
        data_rdata_d  = data_rdata_q;
        data_roaddr_d = data_roaddr_q;
        inst_rdata_d  = inst_rdata_q;
        inst_roaddr_d = inst_roaddr_q;
        MEM_REQ       = 1'b0;
        MEM_WE        = 1'b0;
        MEM_ADDR      = '0;
        MEM_WDATA     = '0;
        tmo_hit       = 1'b0;
        slot_done     = 1'b0;
        rd_word       = '0;

        if (state_q == S_BUSY) begin
            MEM_REQ = 1'b1;
            if (w_vld_q) begin
                MEM_WE    = 1'b1;
                MEM_ADDR  = w_addr_q;
                MEM_WDATA = w_data_q;
            end else if (dr_vld_q) begin
                MEM_ADDR = dr_addr_q;
            end else begin
                MEM_ADDR = ir_addr_q;
            end
            tmo_hit   = (TIMEOUT != 0) && !MEM_ACK && (timer_q == TIMEOUT - 1);
            slot_done = MEM_ACK || tmo_hit;
            rd_word   = tmo_hit ? ERR_DATA : MEM_RDATA;
            if (slot_done) begin
                timer_d = '0;
                if (tmo_hit) err_d = 1'b1;
                if (w_vld_q) begin
                    w_vld_d = 1'b0;
                end else if (dr_vld_q) begin
                    dr_vld_d = 1'b0;
                    dr_res_d = rd_word;
                end else begin
                    ir_vld_d = 1'b0;
                    ir_res_d = rd_word;
                end
                // Result ports only move on RESP entry so they hold while RVALID is low.
                if (!w_vld_d && !dr_vld_d && !ir_vld_d) begin
                    state_d = S_RESP;
                    if (dr_rd_q) begin
                        data_rdata_d  = dr_res_d;
                        data_roaddr_d = dr_addr_q;
                    end
                    if (ir_rd_q) begin
                        inst_rdata_d  = ir_res_d;
                        inst_roaddr_d = ir_addr_q;
                    end
                end
            end else begin
                timer_d = timer_q + 32'd1;
            end
        end else begin
            w_vld_d  = DATA_WREN;
            dr_vld_d = DATA_RDEN;
            ir_vld_d = INST_RDEN;
            dr_rd_d  = DATA_RDEN;
            ir_rd_d  = INST_RDEN;
            timer_d  = '0;
            if (DATA_WREN) begin
                w_addr_d = DATA_WADDR;
                w_data_d = DATA_WDATA;
            end
            if (DATA_RDEN) dr_addr_d = DATA_RIADDR;
            if (INST_RDEN) ir_addr_d = INST_RIADDR;
            if (state_q == S_RESP) err_d = 1'b0;
            state_d = (DATA_WREN || DATA_RDEN || INST_RDEN) ? S_BUSY : S_IDLE;
        end
    end

    assign MEM_WAIT    = (state_q == S_BUSY);
    assign INST_RVALID = (state_q == S_RESP) && ir_rd_q;
    assign DATA_RVALID = (state_q == S_RESP) && dr_rd_q;
    assign BUS_ERR     = (state_q == S_RESP) && err_q;
    assign INST_RDATA  = inst_rdata_q;
    assign INST_ROADDR = inst_roaddr_q;
    assign DATA_RDATA  = data_rdata_q;
    assign DATA_ROADDR = data_roaddr_q;

endmodule
